axi4_slave_mem: RTL

- Parametrised AXI4 slave memory model: the synthesizable responder that sits behind the AXI interface as the DUT/reference slave.
- Independent write (AW/W/B) and read (AR/R) engines.
- Supports FIXED, INCR and WRAP bursts, byte strobes and 8-bit burst length (AXI4).
- Drops the AXI3 write-data ID; error responses flag out-of-range, bad-size and bad-wrap accesses.

---
 rtl/axi4_slave_mem.sv | 339 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) engines over a
// shared word-addressed array. Supports FIXED/INCR/WRAP bursts, byte strobes and
// 8-bit burst length. Bad size, reserved burst, illegal wrap and out-of-range
// beats answer SLVERR; out-of-range is sticky from the offending beat onward.
module axi4_slave_mem #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 8,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                Aclk,
    input  logic                Aresetn,
    input  logic [ID_W-1:0]     AWid,
    input  logic [ADDR_W-1:0]   AWaddr,
    input  logic [LEN_W-1:0]    AWlen,
    input  logic [2:0]          AWsize,
    input  logic [1:0]          AWburst,
    input  logic                AWvalid,
    output logic                AWready,
    input  logic [DATA_W-1:0]   Wdata,
    input  logic [DATA_W/8-1:0] Wstrb,
    input  logic                Wlast,
    input  logic                Wvalid,
    output logic                Wready,
    output logic [ID_W-1:0]     Bid,
    output logic [1:0]          Bresp,
    output logic                Bvalid,
    input  logic                Bready,
    input  logic [ID_W-1:0]     ARid,
    input  logic [ADDR_W-1:0]   ARaddr,
    input  logic [LEN_W-1:0]    ARlen,
    input  logic [2:0]          ARsize,
    input  logic [1:0]          ARburst,
    input  logic                ARvalid,
    output logic                ARready,
    output logic [ID_W-1:0]     Rid,
    output logic [DATA_W-1:0]   Rdata,
    output logic [1:0]          Rresp,
    output logic                Rlast,
    output logic                Rvalid,
    input  logic                Rready
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_W-1:0] beat_step(input logic [2:0] size);
        return ONE_A << size;
    endfunction

    // Errors knowable from the address phase alone.
    function automatic logic cmd_error(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic bad;
        bad = (size > 3'(OFF_W)) || (burst == 2'b11);
        if (burst == BURST_WRAP) begin
            if (!(len == LEN_W'(1) || len == LEN_W'(3) || len == LEN_W'(7) || len == LEN_W'(15)))
                bad = 1'b1;
            if ((addr & (beat_step(size) - ONE_A)) != '0)
                bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                                                    input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] wb;
        logic [ADDR_W-1:0] nxt;
        step = beat_step(size);
        wb   = (ADDR_W'(len) + ONE_A) * step;
        case (burst)
            BURST_INCR: nxt = addr + step;
            BURST_WRAP: nxt = (addr & ~(wb - ONE_A)) | ((addr + step) & (wb - ONE_A));
            default:    nxt = addr;
        endcase
        return nxt;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return (addr >> OFF_W) >= DEPTH_A;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'(addr >> OFF_W);
    endfunction

    // ---------------- write engine ----------------
    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [LEN_W-1:0]  w_len_q, w_len_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [LEN_W-1:0]  w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              w_lerr_q, w_lerr_d;
    logic [ID_W-1:0]   b_id_q, b_id_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic              w_we;
    logic              w_beat_err;
    logic              w_last_bad;
    logic [IDX_W-1:0]  w_idx;

    // Write FSM state register.
    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    // Write FSM next state; Wready is high throughout W_DATA so Wvalid alone is a handshake there.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (AWvalid) w_state_d = W_DATA;
            W_DATA:  if (Wvalid && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
            W_RESP:  if (Bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs decoded from state.
    always_comb begin
        AWready = (w_state_q == W_IDLE);
        Wready  = (w_state_q == W_DATA);
        Bvalid  = (w_state_q == W_RESP);
        Bid     = b_id_q;
        Bresp   = b_resp_q;
    end

    // Write datapath: latch command, track sticky error and Wlast mismatches, build response.
    always_comb begin
        w_id_d     = w_id_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_size_d   = w_size_q;
        w_burst_d  = w_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        w_lerr_d   = w_lerr_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        w_we       = 1'b0;
        w_beat_err = w_err_q | out_of_range(w_addr_q);
        w_last_bad = (Wlast != (w_cnt_q == w_len_q));
        w_idx      = word_idx(w_addr_q);
        case (w_state_q)
            W_IDLE: begin
                if (AWvalid) begin
                    w_id_d    = AWid;
                    w_addr_d  = AWaddr;
                    w_len_d   = AWlen;
                    w_size_d  = AWsize;
                    w_burst_d = AWburst;
                    w_err_d   = cmd_error(AWaddr, AWlen, AWsize, AWburst);
                    w_cnt_d   = '0;
                    w_lerr_d  = 1'b0;
                end
            end
            W_DATA: begin
                if (Wvalid) begin
                    w_we     = !w_beat_err;
                    w_err_d  = w_beat_err;
                    w_lerr_d = w_lerr_q | w_last_bad;
                    w_cnt_d  = w_cnt_q + LEN_W'(1);
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    if (w_cnt_q == w_len_q) begin
                        b_id_d   = w_id_q;
                        b_resp_d = (w_beat_err || w_lerr_q || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            default: ;
        endcase
    end

    // Write control registers.
    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) begin
            w_cnt_q  <= '0;
            w_err_q  <= 1'b0;
            w_lerr_q <= 1'b0;
            b_id_q   <= '0;
            b_resp_q <= RESP_OKAY;
        end else begin
            w_cnt_q  <= w_cnt_d;
            w_err_q  <= w_err_d;
            w_lerr_q <= w_lerr_d;
            b_id_q   <= b_id_d;
            b_resp_q <= b_resp_d;
        end
    end

    // Latched write command fields; only meaningful once a burst has been accepted.
    always_ff @(posedge Aclk) begin
        w_id_q    <= w_id_d;
        w_addr_q  <= w_addr_d;
        w_len_q   <= w_len_d;
        w_size_q  <= w_size_d;
        w_burst_q <= w_burst_d;
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge Aclk) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (Wstrb[i]) mem[w_idx][8*i +: 8] <= Wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [LEN_W-1:0]  r_len_q, r_len_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [LEN_W-1:0]  r_cnt_q, r_cnt_d;
    logic              r_err_q, r_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              r_take_ar, r_take_next;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_beat_err;
    logic [DATA_W-1:0] r_word;

    // Read FSM state register.
    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    // Read FSM next state; leaves R_DATA on the handshake of the last beat.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ARvalid) r_state_d = R_DATA;
            R_DATA:  if (Rready && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        ARready = (r_state_q == R_IDLE);
        Rvalid  = (r_state_q == R_DATA);
        Rid     = r_id_q;
        Rdata   = rdata_q;
        Rresp   = rresp_q;
        Rlast   = rlast_q;
    end

    // Fetch address: beat 0 straight from AR, later beats from the sequencer.
    always_comb begin
        r_take_ar    = (r_state_q == R_IDLE) && ARvalid;
        r_take_next  = (r_state_q == R_DATA) && Rready && !rlast_q;
        r_fetch_addr = r_take_ar ? ARaddr : next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        r_beat_err   = (r_take_ar ? cmd_error(ARaddr, ARlen, ARsize, ARburst) : r_err_q)
                       | out_of_range(r_fetch_addr);
    end

    assign r_word = mem[word_idx(r_fetch_addr)];

    // Read datapath: registered fetch keeps the presented beat stable until it is taken.
    always_comb begin
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        if (r_take_ar) begin
            r_id_d    = ARid;
            r_len_d   = ARlen;
            r_size_d  = ARsize;
            r_burst_d = ARburst;
            r_cnt_d   = '0;
            rlast_d   = (ARlen == '0);
        end else if (r_take_next) begin
            r_cnt_d = r_cnt_q + LEN_W'(1);
            rlast_d = ((r_cnt_q + LEN_W'(1)) == r_len_q);
        end else if ((r_state_q == R_DATA) && Rready) begin
            rlast_d = 1'b0;
        end
        if (r_take_ar || r_take_next) begin
            r_addr_d = r_fetch_addr;
            r_err_d  = r_beat_err;
            rdata_d  = r_beat_err ? '0 : r_word;
            rresp_d  = r_beat_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Read control and output registers.
    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) begin
            r_id_q  <= '0;
            r_cnt_q <= '0;
            r_err_q <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else begin
            r_id_q  <= r_id_d;
            r_cnt_q <= r_cnt_d;
            r_err_q <= r_err_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
        end
    end

    // Latched read command fields.
    always_ff @(posedge Aclk) begin
        r_addr_q  <= r_addr_d;
        r_len_q   <= r_len_d;
        r_size_q  <= r_size_d;
        r_burst_q <= r_burst_d;
    end

endmodule
